// File: rtl/thread_register_file.sv
// rtl/thread_register_file.sv - per-thread register file: REQUEST operand latch, UPDATE write-back, identity registers
// R13 tracks block_id every edge; R14/R15 are lane constants.
module thread_register_file #(
  parameter int DATA_BITS         = 16,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DATA_BITS-1:0] block_id,
  input  logic [2:0]           core_state,
  input  logic [3:0]           decoded_rd_address,
  input  logic [3:0]           decoded_rs_address,
  input  logic [3:0]           decoded_rt_address,
  input  logic                 decoded_reg_write_enable,
  input  logic [1:0]           decoded_reg_input_mux,
  input  logic [7:0]           decoded_immediate,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic [DATA_BITS-1:0] fma_out,
  output logic [DATA_BITS-1:0] rs,
  output logic [DATA_BITS-1:0] rt
);

  localparam logic [2:0] ST_REQUEST = 3'b011;
  localparam logic [2:0] ST_UPDATE  = 3'b110;

  localparam logic [1:0] MUX_ALU = 2'b00;
  localparam logic [1:0] MUX_LSU = 2'b01;
  localparam logic [1:0] MUX_IMM = 2'b10;

  localparam logic [DATA_BITS-1:0] TPB_VAL = DATA_BITS'(THREADS_PER_BLOCK);
  localparam logic [DATA_BITS-1:0] TID_VAL = DATA_BITS'(THREAD_ID);

  logic [DATA_BITS-1:0] regs_q [16];
  logic [DATA_BITS-1:0] regs_d [16];
  logic [DATA_BITS-1:0] rs_q, rs_d;
  logic [DATA_BITS-1:0] rt_q, rt_d;
  logic [DATA_BITS-1:0] wb_data;
  logic                 wb_en;
  logic                 req_en;

  always_comb begin
    wb_data = fma_out;
    case (decoded_reg_input_mux)
      MUX_ALU: wb_data = alu_out;
      MUX_LSU: wb_data = lsu_out;
      MUX_IMM: wb_data = {{(DATA_BITS-8){1'b0}}, decoded_immediate};
      default: wb_data = fma_out;
    endcase
  end

  assign wb_en  = enable && (core_state == ST_UPDATE) && decoded_reg_write_enable
                  && (decoded_rd_address <= 4'd12);
  assign req_en = enable && (core_state == ST_REQUEST);

  always_comb begin
    regs_d = regs_q;
    rs_d   = rs_q;
    rt_d   = rt_q;
    if (wb_en) begin
      regs_d[decoded_rd_address] = wb_data;
    end
    if (req_en) begin
      rs_d = regs_q[decoded_rs_address];
      rt_d = regs_q[decoded_rt_address];
    end
    // Identity registers override any write; R13 follows block_id regardless of enable.
    regs_d[13] = block_id;
    regs_d[14] = TPB_VAL;
    regs_d[15] = TID_VAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      regs_q[14] <= TPB_VAL;
      regs_q[15] <= TID_VAL;
      rs_q       <= '0;
      rt_q       <= '0;
    end else begin
      regs_q <= regs_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
    end
  end

  assign rs = rs_q;
  assign rt = rt_q;

endmodule

// File: tb/tb_thread_register_file.sv
// tb/tb_thread_register_file.sv - table-driven scoreboard bench for thread_register_file
// Each step pushes the expected rs/rt for the coming edge; the check after the edge pops it.
module tb_thread_register_file;

  localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, DECODE = 3'b010, REQUEST = 3'b011;
  localparam logic [2:0] WAITS = 3'b100, EXECUTE = 3'b101, UPDATE = 3'b110;
  localparam logic [1:0] M_ALU = 2'b00, M_LSU = 2'b01, M_IMM = 2'b10, M_FMA = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] block_id;
  logic [2:0]  core_state;
  logic [3:0]  rd_a, rs_a, rt_a;
  logic        we;
  logic [1:0]  mux;
  logic [7:0]  imm;
  logic [15:0] alu_out, lsu_out, fma_out;
  logic [15:0] rs, rt;

  thread_register_file #(
    .DATA_BITS(16), .THREADS_PER_BLOCK(4), .THREAD_ID(2)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
    .core_state(core_state),
    .decoded_rd_address(rd_a), .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
    .decoded_immediate(imm),
    .alu_out(alu_out), .lsu_out(lsu_out), .fma_out(fma_out),
    .rs(rs), .rt(rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic        en;
    logic        we;
    logic [3:0]  rd;
    logic [3:0]  rsa;
    logic [3:0]  rta;
    logic [1:0]  mux;
    logic [7:0]  imm;
    logic [15:0] src;
    logic [15:0] bid;
    logic [15:0] exp_rs;
    logic [15:0] exp_rt;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] rs;
    logic [15:0] rt;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(string name, logic [2:0] st, logic en, logic we, logic [3:0] rd,
                              logic [3:0] rsa, logic [3:0] rta, logic [1:0] mux, logic [7:0] imm,
                              logic [15:0] src, logic [15:0] bid, logic [15:0] ers, logic [15:0] ert);
    vec_t v;
    v.name = name; v.st = st; v.en = en; v.we = we; v.rd = rd; v.rsa = rsa; v.rta = rta;
    v.mux = mux; v.imm = imm; v.src = src; v.bid = bid; v.exp_rs = ers; v.exp_rt = ert;
    return v;
  endfunction

  // Only the selected source carries src; the others carry distinct junk so a wrong mux shows.
  task automatic step(input vec_t v, input logic rst);
    exp_t e;
    @(negedge clk);
    reset      = rst;
    enable     = v.en;
    core_state = v.st;
    we         = v.we;
    rd_a       = v.rd;
    rs_a       = v.rsa;
    rt_a       = v.rta;
    mux        = v.mux;
    imm        = v.imm;
    block_id   = v.bid;
    alu_out    = (v.mux == M_ALU) ? v.src : 16'h1111;
    lsu_out    = (v.mux == M_LSU) ? v.src : 16'h2222;
    fma_out    = (v.mux == M_FMA) ? v.src : 16'h3333;
    e.name = v.name; e.rs = v.exp_rs; e.rt = v.exp_rt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (rs !== e.rs) begin
      errors++;
      $display("FAIL %s rs: got %h expected %h", e.name, rs, e.rs);
    end
    checks++;
    if (rt !== e.rt) begin
      errors++;
      $display("FAIL %s rt: got %h expected %h", e.name, rt, e.rt);
    end
  endtask

  initial begin
    // name, state, en, we, rd, rs, rt, mux, imm, src, block_id, exp rs, exp rt
    tbl.push_back(mk("req_id",      REQUEST, 1, 0,  0, 14, 15, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0004, 16'h0002));
    tbl.push_back(mk("req_r0_r12",  REQUEST, 1, 0,  0,  0, 12, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0000, 16'h0000));
    tbl.push_back(mk("upd_imm",     UPDATE,  1, 1,  3,  1,  2, M_IMM, 8'hA5, 16'h0000, 16'd3, 16'h0000, 16'h0000));
    tbl.push_back(mk("req_imm",     REQUEST, 1, 0,  0,  3, 13, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h00A5, 16'h0003));
    tbl.push_back(mk("upd_alu",     UPDATE,  1, 1,  3,  0,  0, M_ALU, 8'h00, 16'h1234, 16'd3, 16'h00A5, 16'h0003));
    tbl.push_back(mk("req_alu",     REQUEST, 1, 0,  0,  3,  0, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h1234, 16'h0000));
    tbl.push_back(mk("upd_fma",     UPDATE,  1, 1,  3,  0,  0, M_FMA, 8'h00, 16'h8000, 16'd3, 16'h1234, 16'h0000));
    tbl.push_back(mk("req_fma",     REQUEST, 1, 0,  0,  3,  3, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h8000, 16'h8000));
    tbl.push_back(mk("upd_r15",     UPDATE,  1, 1, 15,  0,  0, M_LSU, 8'h00, 16'hFFFF, 16'd3, 16'h8000, 16'h8000));
    tbl.push_back(mk("upd_r14",     UPDATE,  1, 1, 14,  0,  0, M_LSU, 8'h00, 16'hFFFF, 16'd3, 16'h8000, 16'h8000));
    tbl.push_back(mk("upd_r13",     UPDATE,  1, 1, 13,  0,  0, M_LSU, 8'h00, 16'hFFFF, 16'd3, 16'h8000, 16'h8000));
    tbl.push_back(mk("req_ro_id",   REQUEST, 1, 0,  0, 15, 14, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0002, 16'h0004));
    tbl.push_back(mk("req_r13",     REQUEST, 1, 0,  0, 13, 13, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0003, 16'h0003));
    tbl.push_back(mk("dis_req",     REQUEST, 0, 0,  0, 15, 14, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0003, 16'h0003));
    tbl.push_back(mk("dis_upd",     UPDATE,  0, 1,  5,  0,  0, M_IMM, 8'h07, 16'h0000, 16'd3, 16'h0003, 16'h0003));
    tbl.push_back(mk("dis_chk_r5",  REQUEST, 1, 0,  0,  5, 15, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0000, 16'h0002));
    tbl.push_back(mk("en_upd",      UPDATE,  1, 1,  5,  0,  0, M_IMM, 8'h07, 16'h0000, 16'd3, 16'h0000, 16'h0002));
    tbl.push_back(mk("en_chk_r5",   REQUEST, 1, 0,  0,  5,  5, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0007, 16'h0007));
    tbl.push_back(mk("st_fetch",    FETCH,   1, 1,  5,  1,  2, M_IMM, 8'h55, 16'h0000, 16'd3, 16'h0007, 16'h0007));
    tbl.push_back(mk("st_decode",   DECODE,  1, 1,  6,  3,  4, M_ALU, 8'h00, 16'hAAAA, 16'd3, 16'h0007, 16'h0007));
    tbl.push_back(mk("st_wait",     WAITS,   1, 1,  5, 14, 15, M_IMM, 8'h55, 16'h0000, 16'd3, 16'h0007, 16'h0007));
    tbl.push_back(mk("st_exec",     EXECUTE, 1, 1,  6, 13,  0, M_FMA, 8'h00, 16'hBBBB, 16'd3, 16'h0007, 16'h0007));
    tbl.push_back(mk("st_chk",      REQUEST, 1, 0,  0,  5,  6, M_ALU, 8'h00, 16'h0000, 16'd3, 16'h0007, 16'h0000));
    tbl.push_back(mk("bid_old",     REQUEST, 1, 0,  0, 13,  0, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0003, 16'h0000));
    tbl.push_back(mk("bid_new",     REQUEST, 1, 0,  0, 13,  0, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0009, 16'h0000));
    tbl.push_back(mk("upd_r12",     UPDATE,  1, 1, 12,  0,  0, M_ALU, 8'h00, 16'hBEEF, 16'd9, 16'h0009, 16'h0000));
    tbl.push_back(mk("req_r12",     REQUEST, 1, 0,  0, 12,  3, M_ALU, 8'h00, 16'h0000, 16'd9, 16'hBEEF, 16'h8000));

    reset = 1'b1; enable = 1'b0; block_id = '0; core_state = IDLE; rd_a = '0; rs_a = '0; rt_a = '0;
    we = 1'b0; mux = '0; imm = '0; alu_out = '0; lsu_out = '0; fma_out = '0;

    step(mk("reset", IDLE, 1, 0, 0, 0, 0, M_ALU, 8'h00, 16'h0000, 16'd0, 16'h0000, 16'h0000), 1'b1);

    foreach (tbl[i]) step(tbl[i], 1'b0);

    // Reset mid-instruction: R7 written, then reset lands during WAIT.
    step(mk("r7_upd",   UPDATE,  1, 1, 7,  0, 0, M_ALU, 8'h00, 16'h0042, 16'd9, 16'hBEEF, 16'h8000), 1'b0);
    step(mk("r7_req",   REQUEST, 1, 0, 0,  7, 7, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0042, 16'h0042), 1'b0);
    step(mk("rst_wait", WAITS,   1, 1, 4,  7, 7, M_ALU, 8'h00, 16'h7777, 16'd9, 16'h0000, 16'h0000), 1'b1);
    step(mk("post_idle", IDLE,   1, 0, 0,  0, 0, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0000, 16'h0000), 1'b0);
    step(mk("post_r7",  REQUEST, 1, 0, 0,  7, 13, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0000, 16'h0009), 1'b0);
    step(mk("post_id",  REQUEST, 1, 0, 0, 14, 15, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0004, 16'h0002), 1'b0);
    step(mk("post_r4",  REQUEST, 1, 0, 0,  4, 12, M_ALU, 8'h00, 16'h0000, 16'd9, 16'h0000, 16'h0000), 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
